// File: rtl/ram_sched_pkg.sv
// rtl/ram_sched_pkg.sv - shared types and constants for the 1RW byte-mask RAM scheduler
package ram_sched_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    typedef enum logic {
        PRIO_WR,
        PRIO_RD
    } prio_e;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/ram_1rw_byte_mask_out_reg.sv
// rtl/ram_1rw_byte_mask_out_reg.sv - single-port byte-masked RAM, 2-cycle registered read
module ram_1rw_byte_mask_out_reg #(
    parameter int DATA_W      = 512,
    parameter int DATA_MASK_W = DATA_W / 8,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   en_a,
    input  logic [ADDR_W-1:0]      addr_a,
    input  logic [DATA_W-1:0]      din_a,
    input  logic [DATA_MASK_W-1:0] wr_mask_a,
    output logic [DATA_W-1:0]      dout_a
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Array read then output register; dout_a carries a read two edges after en_a.
    always_ff @(posedge clk) begin
        if (en_a) begin
            for (int b = 0; b < DATA_MASK_W; b++) begin
                if (wr_mask_a[b]) begin
                    mem[addr_a][b*8 +: 8] <= din_a[b*8 +: 8];
                end
            end
            rd_q <= mem[addr_a];
        end
        dout_a <= rd_q;
    end

endmodule

// File: rtl/ram_sched_resp_fifo.sv
// rtl/ram_sched_resp_fifo.sv - read response FIFO with count and full/empty, head visible when non-empty
module ram_sched_resp_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_1rw_byte_mask_sched.sv
// rtl/ram_1rw_byte_mask_sched.sv - write/read arbiter over one 1RW RAM with credit-protected response FIFO; optional RAM_SCHED_PERF_CNT_EN
module ram_1rw_byte_mask_sched
    import ram_sched_pkg::*;
#(
    parameter int DATA_W      = 512,
    parameter int DATA_MASK_W = DATA_W / 8,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int RESP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req_val,
    input  logic [ADDR_W-1:0]      wr_req_addr,
    input  logic [DATA_W-1:0]      wr_req_data,
    input  logic [DATA_MASK_W-1:0] wr_req_mask,
    output logic                   wr_req_rdy,
    input  logic                   rd_req_val,
    input  logic [ADDR_W-1:0]      rd_req_addr,
    output logic                   rd_req_rdy,
    output logic                   rd_resp_val,
    output logic [DATA_W-1:0]      rd_resp_data,
    input  logic                   rd_resp_rdy
`ifdef RAM_SCHED_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]  wr_grant_cnt,
    output logic [PERF_CNT_W-1:0]  rd_grant_cnt,
    output logic [PERF_CNT_W-1:0]  conflict_cnt
`endif
);

    localparam int CRED_W = $clog2(RESP_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(RESP_DEPTH);

    grant_e                 gnt;
    prio_e                  prio_q;
    logic [CRED_W-1:0]      credit_q;
    logic                   rst_active;
    logic                   rd_elig;
    logic                   contested;
    logic                   rd_gnt;
    logic                   resp_pop;
    logic                   p0;
    logic                   p1;
    logic                   en_a;
    logic [ADDR_W-1:0]      addr_a;
    logic [DATA_MASK_W-1:0] wr_mask_a;
    logic [DATA_W-1:0]      dout_a;
    logic [CRED_W-1:0]      fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rst_active = ~rst;
    assign rd_elig    = (credit_q != '0);
    assign contested  = wr_req_val & rd_req_val & rd_elig;

    // Readys look only at the other port's valid, so a requester never sees its own valid loop back.
    always_comb begin
        wr_req_rdy = ~rst_active & ~(rd_req_val & rd_elig & (prio_q == PRIO_RD));
        rd_req_rdy = ~rst_active & rd_elig & ~(wr_req_val & (prio_q == PRIO_WR));
        gnt        = GNT_NONE;
        if (wr_req_val & wr_req_rdy) begin
            gnt = GNT_WR;
        end else if (rd_req_val & rd_req_rdy) begin
            gnt = GNT_RD;
        end
    end

    assign rd_gnt    = (gnt == GNT_RD);
    assign en_a      = (gnt != GNT_NONE);
    assign addr_a    = (gnt == GNT_WR) ? wr_req_addr : rd_req_addr;
    assign wr_mask_a = (gnt == GNT_WR) ? wr_req_mask : '0;
    assign resp_pop  = rd_resp_val & rd_resp_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p0       <= 1'b0;
            p1       <= 1'b0;
            prio_q   <= PRIO_WR;
            credit_q <= CRED_INIT;
        end else begin
            p0 <= rd_gnt;
            p1 <= p0;
            if (contested) begin
                prio_q <= (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
            end
            case ({rd_gnt, resp_pop})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01:   credit_q <= credit_q + 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    ram_1rw_byte_mask_out_reg #(
        .DATA_W      (DATA_W),
        .DATA_MASK_W (DATA_MASK_W),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .en_a      (en_a),
        .addr_a    (addr_a),
        .din_a     (wr_req_data),
        .wr_mask_a (wr_mask_a),
        .dout_a    (dout_a)
    );

    ram_sched_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH),
        .CNT_W  (CRED_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (p1),
        .push_data (dout_a),
        .pop       (resp_pop),
        .head_data (rd_resp_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_resp_val = ~fifo_empty;

    // Every credit is either free, riding the latency pipe, or parked in the FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(p1 && fifo_full));
    a_credit_sum: assert property (@(posedge clk) disable iff (!rst)
        (32'(credit_q) + 32'(fifo_count) + 32'(p0) + 32'(p1)) == 32'(RESP_DEPTH));

`ifdef RAM_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_grant_cnt <= '0;
            rd_grant_cnt <= '0;
            conflict_cnt <= '0;
        end else begin
            if ((gnt == GNT_WR) && (wr_grant_cnt != '1)) begin
                wr_grant_cnt <= wr_grant_cnt + 1'b1;
            end
            if (rd_gnt && (rd_grant_cnt != '1)) begin
                rd_grant_cnt <= rd_grant_cnt + 1'b1;
            end
            if (contested && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
